// File: rtl/img_scaler.sv
// img_scaler -- nearest-neighbour image scaler between a source ROM and a
// destination RAM.
//
// Zoom-in (mode=0) replicates each source pixel into a factor x factor block.
// Zoom-out (mode=1) keeps one source pixel per factor x factor block. With
// IMG_SCALER_AVG_EN defined, zoom-out instead writes the truncated mean of
// the block. Legal factors are 1, 2 and 4. Any other factor presented with
// start gives a one-cycle err pulse, and the request is dropped.
//
// Optional feature macro: IMG_SCALER_AVG_EN (block averaging in zoom-out).
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        single-cycle frame request (ignored while busy)
//   mode         0 = zoom-in, 1 = zoom-out (latched at start)
//   factor       scale factor 1/2/4 (latched at start)
//   rom_addr     registered source read address
//   rom_data     source pixel, valid one cycle after rom_addr changes
//   ram_addr     registered destination write address
//   ram_data     registered destination pixel
//   ram_we       write strobe, high only in WRITE, one pixel per cycle
//   busy         frame in progress
//   done         one-cycle pulse in DONE after the last write
//   err          one-cycle pulse for an illegal factor request
//
// Handshake: ram_we/ram_addr/ram_data form a fire-and-forget write port (no
// back-pressure); rom_addr is presented for a full cycle (READ), and the data
// it returns is sampled at the end of the following cycle (WAIT).
module img_scaler #(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [2:0]        factor,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_data,
  output logic              ram_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);
  localparam logic [ADDR_W-1:0] SRC_H_A = ADDR_W'(SRC_H);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_t            state;
  logic              mode_q;
  logic [1:0]        sh_q;        // log2(factor)
  // row/col: source pixel in zoom-in, output pixel in zoom-out.
  logic [ADDR_W-1:0] row, col;
  // sub_i/sub_j: replica offset (zoom-in writes) or block offset (averaging reads).
  logic [1:0]        sub_i, sub_j;

`ifdef IMG_SCALER_AVG_EN
  logic [PIX_W+3:0]  sum;
  logic [PIX_W+3:0]  sum_tot;
  assign sum_tot = sum + (PIX_W+4)'(rom_data);
`endif

  // Look-ahead values, so every registered address is loaded on the same
  // edge that enters the state which uses it.
  logic [1:0]        f_m1;
  logic              sub_last;
  logic [1:0]        sub_i_n, sub_j_n;
  logic [ADDR_W-1:0] last_row, last_col, row_n, col_n;
  logic              pix_last;

  always_comb begin
    f_m1     = 2'((3'd1 << sh_q) - 3'd1);
    sub_last = (sub_i == f_m1) && (sub_j == f_m1);
    sub_i_n  = sub_i;
    sub_j_n  = sub_j + 2'd1;
    if (sub_j == f_m1) begin
      sub_j_n = 2'd0;
      sub_i_n = sub_i + 2'd1;
    end
    last_row = (mode_q ? (SRC_H_A >> sh_q) : SRC_H_A) - ONE;
    last_col = (mode_q ? (SRC_W_A >> sh_q) : SRC_W_A) - ONE;
    pix_last = (row == last_row) && (col == last_col);
    row_n    = row;
    col_n    = col + ONE;
    if (col == last_col) begin
      col_n = '0;
      row_n = row + ONE;
    end
  end

  // Source address. Zoom-in reads (r, c) directly; zoom-out reads pixel
  // (r*factor + i, c*factor + j) of the source.
  function automatic logic [ADDR_W-1:0] src_addr(
    input logic m, input logic [1:0] sh,
    input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] c,
    input logic [1:0] i, input logic [1:0] j);
    logic [1:0] s;
    s = m ? sh : 2'd0;
    return (((r << s) + ADDR_W'(i)) * SRC_W_A) + (c << s) + ADDR_W'(j);
  endfunction

  // Destination address. Output width is SRC_W*factor (zoom-in) or
  // SRC_W/factor (zoom-out); SRC_W is a multiple of 4, so the shift is exact.
  function automatic logic [ADDR_W-1:0] dst_addr(
    input logic m, input logic [1:0] sh,
    input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] c,
    input logic [1:0] i, input logic [1:0] j);
    if (m)
      return ((r * SRC_W_A) >> sh) + c;
    else
      return ((((r << sh) + ADDR_W'(i)) * SRC_W_A) << sh) + (c << sh) + ADDR_W'(j);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      sh_q     <= 2'd0;
      row      <= '0;
      col      <= '0;
      sub_i    <= 2'd0;
      sub_j    <= 2'd0;
      rom_addr <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef IMG_SCALER_AVG_EN
      sum      <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (factor == 3'd1 || factor == 3'd2 || factor == 3'd4) begin
              mode_q   <= mode;
              sh_q     <= (factor == 3'd4) ? 2'd2 : (factor == 3'd2) ? 2'd1 : 2'd0;
              row      <= '0;
              col      <= '0;
              sub_i    <= 2'd0;
              sub_j    <= 2'd0;
              rom_addr <= '0;       // first source pixel is always address 0
              busy     <= 1'b1;
              state    <= READ;
`ifdef IMG_SCALER_AVG_EN
              sum      <= '0;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end

        READ: state <= WAIT;

        WAIT: begin
`ifdef IMG_SCALER_AVG_EN
          if (mode_q && !sub_last) begin
            // Accumulate and fetch the next pixel of the block.
            sum      <= sum_tot;
            sub_i    <= sub_i_n;
            sub_j    <= sub_j_n;
            rom_addr <= src_addr(mode_q, sh_q, row, col, sub_i_n, sub_j_n);
            state    <= READ;
          end else if (mode_q) begin
            ram_data <= PIX_W'(sum_tot >> {sh_q, 1'b0});
            sum      <= '0;
            sub_i    <= 2'd0;
            sub_j    <= 2'd0;
            ram_addr <= dst_addr(mode_q, sh_q, row, col, 2'd0, 2'd0);
            ram_we   <= 1'b1;
            state    <= WRITE;
          end else begin
            ram_data <= rom_data;
            ram_addr <= dst_addr(mode_q, sh_q, row, col, 2'd0, 2'd0);
            ram_we   <= 1'b1;
            state    <= WRITE;
          end
`else
          ram_data <= rom_data;
          ram_addr <= dst_addr(mode_q, sh_q, row, col, 2'd0, 2'd0);
          ram_we   <= 1'b1;
          state    <= WRITE;
`endif
        end

        WRITE: begin
          if (!mode_q && !sub_last) begin
            // Next replica of the same source pixel.
            sub_i    <= sub_i_n;
            sub_j    <= sub_j_n;
            ram_addr <= dst_addr(mode_q, sh_q, row, col, sub_i_n, sub_j_n);
          end else begin
            ram_we <= 1'b0;
            sub_i  <= 2'd0;
            sub_j  <= 2'd0;
            if (pix_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row      <= row_n;
              col      <= col_n;
              rom_addr <= src_addr(mode_q, sh_q, row_n, col_n, 2'd0, 2'd0);
              state    <= READ;
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_scaler.sv
// tb_img_scaler -- directed test of img_scaler on a 4x4 source whose pixel
// value equals its address. Writes are logged from the RAM port and compared
// against expected (address, data) pairs held in exp_q.
module tb_img_scaler;

  localparam int SRC_W  = 4;
  localparam int SRC_H  = 4;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [2:0]        factor = 3'd1;
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [PIX_W-1:0]  ram_data;
  logic              ram_we;
  logic              busy;
  logic              done;
  logic              err;

  img_scaler #(.SRC_W(SRC_W), .SRC_H(SRC_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .factor(factor),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .busy(busy), .done(done), .err(err)
  );

  // Synchronous source ROM: pixel value = address.
  always @(posedge clk) rom_data <= PIX_W'(rom_addr);

  // Destination RAM.
  logic [PIX_W-1:0] ram [256];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_data;

  // Scoreboard
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int done_cnt = 0;
  int err_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write / pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (ram_we) begin
      got_q.push_back({ram_addr, ram_data});
      check("we_implies_busy", 32'(busy), 32'd1);
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_data"}, 32'(ram_data), 32'd0);
    check({tag, "_ram_we"},   32'(ram_we),   32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
  endtask

  // Driver: start a frame, optionally pulse an illegal start at cycle
  // mid_start (0 = none), and wait (bounded) for done.
  task automatic run_frame(input logic m, input logic [2:0] f, input int mid_start,
                           output int cyc);
    @(negedge clk);
    start = 1'b1; mode = m; factor = f;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == mid_start) begin
        start = 1'b1; mode = ~m; factor = 3'd3;
      end else begin
        start = 1'b0;
      end
    end
    check("frame_done_seen", 32'(done), 32'd1);
    check("busy_low_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int cyc1;
    int cyc2;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("after_reset");

    // Zoom-in, factor 2: 64 writes, each source pixel into a 2x2 block.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int di = 0; di < 2; di++)
          for (int dj = 0; dj < 2; dj++)
            exp_q.push_back({8'((r * 2 + di) * 8 + c * 2 + dj), 8'(r * 4 + c)});
    run_frame(1'b0, 3'd2, 0, cyc1);
    compare_writes("zoomin_f2");
    check("zin_ram0",  32'(ram[0]),  32'd0);
    check("zin_ram1",  32'(ram[1]),  32'd0);
    check("zin_ram8",  32'(ram[8]),  32'd0);
    check("zin_ram9",  32'(ram[9]),  32'd0);
    check("zin_ram6",  32'(ram[6]),  32'd3);
    check("zin_ram7",  32'(ram[7]),  32'd3);
    check("zin_ram14", 32'(ram[14]), 32'd3);
    check("zin_ram15", 32'(ram[15]), 32'd3);
    check("zin_done_count", 32'(done_cnt), 32'd1);

    // Same frame with a start pulse mid-frame: must be ignored.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int di = 0; di < 2; di++)
          for (int dj = 0; dj < 2; dj++)
            exp_q.push_back({8'((r * 2 + di) * 8 + c * 2 + dj), 8'(r * 4 + c)});
    run_frame(1'b0, 3'd2, 20, cyc2);
    compare_writes("midstart");
    check("midstart_timing", 32'(cyc2), 32'(cyc1));
    check("midstart_done_count", 32'(done_cnt), 32'd2);
    check("midstart_no_err", 32'(err_cnt), 32'd0);

    // Zoom-out, factor 2.
`ifdef IMG_SCALER_AVG_EN
    exp_q.push_back({8'd0, 8'd2});
    exp_q.push_back({8'd1, 8'd4});
    exp_q.push_back({8'd2, 8'd10});
    exp_q.push_back({8'd3, 8'd12});
`else
    exp_q.push_back({8'd0, 8'd0});
    exp_q.push_back({8'd1, 8'd2});
    exp_q.push_back({8'd2, 8'd8});
    exp_q.push_back({8'd3, 8'd10});
`endif
    run_frame(1'b1, 3'd2, 0, cyc1);
    compare_writes("zoomout_f2");

    // Zoom-out, factor 4: one write, address 0, from source pixel 0.
`ifdef IMG_SCALER_AVG_EN
    exp_q.push_back({8'd0, 8'd7});   // (0+1+...+15)/16 = 120/16 = 7
`else
    exp_q.push_back({8'd0, 8'd0});
`endif
    run_frame(1'b1, 3'd4, 0, cyc1);
    compare_writes("zoomout_f4");

    // Illegal factor 3: err one cycle, no busy, no writes.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; factor = 3'd3;
    @(negedge clk);
    start = 1'b0;
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("illegal_err_one_cycle", 32'(err), 32'd0);
    repeat (10) @(negedge clk);
    check("illegal_busy_later", 32'(busy), 32'd0);
    check("illegal_no_writes", 32'(got_q.size()), 32'd0);
    check("illegal_err_count", 32'(err_cnt), 32'd1);

    // Reset after 10 writes of a factor-4 zoom-in frame.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; factor = 3'd4;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (got_q.size() < 10 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("f4_ten_writes", 32'(got_q.size()), 32'd10);
    check("f4_we_at_reset", 32'(ram_we), 32'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("midframe_reset");
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    repeat (20) @(negedge clk);
    check("no_resume_busy", 32'(busy), 32'd0);
    check("no_resume_writes", 32'(got_q.size()), 32'd0);

    // Factor 1 after reset: straight copy.
    for (int a = 0; a < 16; a++) exp_q.push_back({8'(a), 8'(a)});
    run_frame(1'b0, 3'd1, 0, cyc1);
    compare_writes("copy_f1");

    // Factor 1 zoom-out is also a straight copy.
    for (int a = 0; a < 16; a++) exp_q.push_back({8'(a), 8'(a)});
    run_frame(1'b1, 3'd1, 0, cyc1);
    compare_writes("copy_f1_out");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/img_scaler.md
IMG_SCALER -- requirements
Module: img_scaler

Interface
REQ-001 SHALL have parameter SRC_W, default 160, source image width in pixels.
REQ-002 SHALL have parameter SRC_H, default 120, source image height in pixels.
REQ-003 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-004 SHALL have parameter ADDR_W, default 19, ROM and RAM address width.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  single-cycle request to begin a frame.
REQ-008 SHALL have port mode  input  1  0 = zoom-in (replicate), 1 = zoom-out (decimate).
REQ-009 SHALL have port factor  input  3  scale factor; legal values 1, 2, 4.
REQ-010 SHALL have port rom_addr  output  ADDR_W  source ROM read address, registered.
REQ-011 SHALL have port rom_data  input  PIX_W  source pixel; valid one cycle after rom_addr changes.
REQ-012 SHALL have port ram_addr  output  ADDR_W  destination RAM write address, registered.
REQ-013 SHALL have port ram_data  output  PIX_W  destination pixel, registered.
REQ-014 SHALL have port ram_we  output  1  destination write strobe, one pixel per asserted cycle.
REQ-015 SHALL have ports busy, done, err  output  1 each  frame active / one-cycle completion pulse / one-cycle illegal-request pulse.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WAIT, WRITE, DONE.
REQ-017 SHALL, in IDLE with start=1, latch mode and factor, then go to READ with busy=1 from the next cycle.
REQ-018 SHALL, if the latched factor is not 1, 2 or 4, pulse err for one cycle, stay in IDLE, and perform no writes.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL, in zoom-in mode, scan source pixels row-major: READ drives rom_addr=r*SRC_W+c, WAIT captures rom_data, then WRITE asserts ram_we for factor*factor consecutive cycles.
REQ-021 SHALL, in zoom-in mode, write ram_addr=(r*factor+di)*(SRC_W*factor)+(c*factor+dj), with dj incrementing fastest, then di.
REQ-022 SHALL, in zoom-out mode, scan output pixels (R,C) row-major over (SRC_H/factor)x(SRC_W/factor), read source (R*factor, C*factor), and write ram_addr=R*(SRC_W/factor)+C in a single WRITE cycle.
REQ-023 SHALL treat factor=1 in either mode as a straight copy: SRC_W*SRC_H writes, ram_addr equal to rom_addr.
REQ-024 SHALL compute all addresses with ADDR_W-bit unsigned arithmetic, with factor multiplies and divides implemented as shifts.
REQ-025 SHALL, after the last write of a frame, enter DONE for one cycle with done=1 and busy=0, then return to IDLE.
REQ-026 SHALL hold ram_we=0 in every state other than WRITE.
REQ-027 SHALL require SRC_W and SRC_H to be multiples of 4 and SRC_W*SRC_H*16 <= 2^ADDR_W; this is a parameter constraint, not a runtime check.

Reset
REQ-028 SHALL, on rst=1 at any time including mid-frame, immediately force state IDLE and clear all counters.
REQ-029 SHALL, on rst=1, drive rom_addr=0, ram_addr=0, ram_data=0, ram_we=0, busy=0, done=0 and err=0.
REQ-030 SHALL not resume an interrupted frame after reset; a new start is required.

Configuration
REQ-031 SHALL support macro IMG_SCALER_AVG_EN.
REQ-032 SHALL, with IMG_SCALER_AVG_EN defined, make zoom-out read all factor*factor source pixels of each block and accumulate them in a PIX_W+4-bit sum, one READ/WAIT pair per pixel.
REQ-033 SHALL, with IMG_SCALER_AVG_EN defined, write ram_data = sum >> (2*log2(factor)), truncated.
REQ-034 SHALL, with IMG_SCALER_AVG_EN undefined, use pure decimation per REQ-022 and synthesise no accumulator.

Verification
REQ-035 SHALL pass this test: SRC 4x4, pixel value = address, mode 0, factor 2 -> 64 writes; RAM[0,1,8,9]=0 and RAM[6,7,14,15]=3; done pulses once.
REQ-036 SHALL pass this test: SRC 4x4, mode 1, factor 2, AVG off -> 4 writes, ram_data 0, 2, 8, 10 at addresses 0 to 3.
REQ-037 SHALL pass this test: SRC 4x4, mode 1, factor 2, AVG on -> ram_data 2, 4, 10, 12 (block means, truncated).
REQ-038 SHALL pass this test: factor=3 with start -> err pulses for one cycle, busy stays 0, ram_we never asserts.
REQ-039 SHALL pass this test: rst asserted after 10 writes of a factor-4 frame -> all outputs 0 in the same cycle; a new start with factor 1 gives 16 writes with ram_addr 0 to 15.
REQ-040 SHALL pass this test: start pulsed again mid-frame -> no effect; write count and done timing are unchanged.
